if_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage core; the producer for the IF/ID pipeline register.
- Owns the PC and issues one word-read request at a time to the memory controller.
- Presents the fetched PC/instruction pair to IF/ID and raises a stall request while no instruction is available.
- Honours the EX-stage branch redirect and the ID-stage hold from the stall controller.

---
 rtl/if_fetch_pkg.sv | 23 ++
 rtl/if_icache.sv | 54 +++++
 rtl/if_fetch.sv | 138 +++++++++++++
 tb/tb_if_fetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants, state encoding and PC helper for the fetch stage
// Contents: reset level, zero word, true/false, stall-vector hold bit, if_state_e, pc_next()
package if_fetch_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        TRUE       = 1'b1;
    localparam logic        FALSE      = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam int          ID_HOLD    = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    // 32-bit modulo increment, so 32'hFFFF_FFFC wraps to 0
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped one-word-per-line instruction cache (lookup/fill/invalidate)
// Ports: clk, rst (sync, clears all valid bits); lookup_pc -> hit, hit_inst;
//        fill_en, fill_pc, fill_inst write one line. Built only when ICACHE_EN is defined.
`ifdef ICACHE_EN
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_inst,
    input  logic        fill_en,
    input  logic [31:0] fill_pc,
    input  logic [31:0] fill_inst
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [IW-1:0]    rd_idx, wr_idx;
    logic             unused;

    assign rd_idx   = lookup_pc[IW+1:2];
    assign wr_idx   = fill_pc[IW+1:2];
    assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_pc[31:IW+2]);
    assign hit_inst = data_q[rd_idx];
    assign unused   = ^{lookup_pc[1:0], fill_pc[1:0]};

    always_comb begin
        valid_d = valid_q;
        if (fill_en) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) valid_q <= '0;
        else                   valid_q <= valid_d;
    end

    // tag/data arrays need no reset: valid bits gate every hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_idx]  <= fill_pc[31:IW+2];
            data_q[wr_idx] <= fill_inst;
        end
    end

endmodule
`endif

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage; owns the PC, issues one word read at a time, feeds IF/ID
// Ports: clk, rst (sync, active-high); stall_state[2]=ID hold; ex_b_flag_i/ex_b_target_i redirect;
//        mem_req_o/mem_addr_o request, mem_ready_i/mem_data_i response;
//        if_pc/if_inst to IF/ID; if_stall_req_o high while no valid instruction.
// Option: ICACHE_EN adds an ICACHE_LINES-line direct-mapped cache (if_icache).
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_state,
    input  logic        ex_b_flag_i,
    input  logic [31:0] ex_b_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_stall_req_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] inst_q, inst_d;
    logic        hit, fill;
    logic [31:0] hit_inst;
    logic        unused;

    assign unused = ^{stall_state[5:3], stall_state[1:0]};

`ifdef ICACHE_EN
    if_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (pc_q),
        .hit       (hit),
        .hit_inst  (hit_inst),
        .fill_en   (fill),
        .fill_pc   (pc_q),
        .fill_inst (mem_data_i)
    );
`else
    assign hit      = FALSE;
    assign hit_inst = ZERO_WORD;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        req_d   = FALSE;
        addr_d  = addr_q;
        ifpc_d  = ifpc_q;
        inst_d  = inst_q;
        fill    = FALSE;
        case (state_q)
            S_IDLE: begin
                if (ex_b_flag_i) begin
                    pc_d = ex_b_target_i;
                end else if (hit) begin
                    ifpc_d  = pc_q;
                    inst_d  = hit_inst;
                    state_d = S_HOLD;
                end else begin
                    req_d   = TRUE;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // the outstanding read cannot be aborted, so remember to drop its data
                if (ex_b_flag_i) begin
                    pc_d   = ex_b_target_i;
                    kill_d = TRUE;
                end
                if (mem_ready_i) begin
                    if (kill_q || ex_b_flag_i) begin
                        kill_d  = FALSE;
                        state_d = S_IDLE;
                    end else begin
                        ifpc_d  = pc_q;
                        inst_d  = mem_data_i;
                        fill    = TRUE;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // redirect beats consume and squashes the held instruction
                if (ex_b_flag_i) begin
                    pc_d    = ex_b_target_i;
                    ifpc_d  = ZERO_WORD;
                    inst_d  = ZERO_WORD;
                    state_d = S_IDLE;
                end else if (!stall_state[ID_HOLD]) begin
                    pc_d    = pc_next(pc_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= FALSE;
            req_q   <= FALSE;
            addr_q  <= ZERO_WORD;
            ifpc_q  <= ZERO_WORD;
            inst_q  <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ifpc_q  <= ifpc_d;
            inst_q  <= inst_d;
        end
    end

    assign mem_req_o      = req_q;
    assign mem_addr_o     = addr_q;
    assign if_pc          = ifpc_q;
    assign if_inst        = inst_q;
    assign if_stall_req_o = (state_q != S_HOLD);

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch (define ICACHE_EN to add the cache pass)
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_state;
    logic        ex_b_flag_i;
    logic [31:0] ex_b_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_data_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall_req_o;

    int checks = 0;
    int errors = 0;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall_state    (stall_state),
        .ex_b_flag_i    (ex_b_flag_i),
        .ex_b_target_i  (ex_b_target_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ready_i    (mem_ready_i),
        .mem_data_i     (mem_data_i),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_stall_req_o (if_stall_req_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n = 0;
        while (!mem_req_o && n < 20) begin
            tick();
            n++;
        end
        chk("req", 32'(mem_req_o), 32'd1);
        chk("req_addr", mem_addr_o, a);
    endtask

    task automatic respond(input logic [31:0] d, input int lat);
        repeat (lat - 1) tick();
        mem_ready_i = 1'b1;
        mem_data_i  = d;
        tick();
        mem_ready_i = 1'b0;
        mem_data_i  = 32'h0;
    endtask

    task automatic chk_hold(input logic [31:0] a, input logic [31:0] d);
        chk("hold_stall", 32'(if_stall_req_o), 32'd0);
        chk("hold_pc", if_pc, a);
        chk("hold_inst", if_inst, d);
    endtask

    task automatic fetch(input logic [31:0] a, input int lat);
        wait_req(a);
        respond(word(a), lat);
        chk_hold(a, word(a));
    endtask

    task automatic branch(input logic [31:0] t);
        ex_b_flag_i   = 1'b1;
        ex_b_target_i = t;
        tick();
        ex_b_flag_i   = 1'b0;
        ex_b_target_i = 32'h0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_state = 6'b0; ex_b_flag_i = 1'b0; ex_b_target_i = 32'h0;
        mem_ready_i = 1'b0; mem_data_i = 32'h0;
        repeat (2) tick();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_stall", 32'(if_stall_req_o), 32'd1);
        rst = 1'b0;
        // sequential fetches, latency 3, one-cycle valid window
        fetch(32'h0, 3);
        tick();
        chk("valid_1cyc_stall", 32'(if_stall_req_o), 32'd1);
        chk("idle_no_req", 32'(mem_req_o), 32'd0);
        fetch(32'h4, 3);
        fetch(32'h8, 3);
        // ID hold at 0x10
        fetch(32'hC, 3);
        fetch(32'h10, 1);
        stall_state = 6'b000100;
        repeat (4) begin
            tick();
            chk_hold(32'h10, word(32'h10));
            chk("held_no_req", 32'(mem_req_o), 32'd0);
        end
        stall_state = 6'b0;
        fetch(32'h14, 2);
        // redirect during S_WAIT for 0x20
        fetch(32'h18, 1);
        fetch(32'h1C, 1);
        wait_req(32'h20);
        tick();
        branch(32'h100);
        respond(32'hBAD0_0020, 1);
        chk("kill_stall", 32'(if_stall_req_o), 32'd1);
        chk("kill_pc", if_pc, 32'h1C);
        fetch(32'h100, 2);
        // redirect during S_HOLD beats consume
        branch(32'h40);
        chk("redir_inst", if_inst, 32'h0);
        chk("redir_pc", if_pc, 32'h0);
        chk("redir_stall", 32'(if_stall_req_o), 32'd1);
        fetch(32'h40, 1);
        // misaligned target passes through unchanged
        branch(32'h203);
        fetch(32'h203, 1);
        fetch(32'h207, 1);
        // PC wrap
        branch(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 1);
        fetch(32'h0, 1);
        // mem_ready_i outside S_WAIT is ignored
        stall_state = 6'b000100;
        mem_ready_i = 1'b1;
        mem_data_i  = 32'h1234_5678;
        tick();
        mem_ready_i = 1'b0;
        mem_data_i  = 32'h0;
        chk_hold(32'h0, word(32'h0));
        stall_state = 6'b0;
        // reset during S_WAIT, late response ignored
        wait_req(32'h4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_req", 32'(mem_req_o), 32'd0);
        chk("mrst_addr", mem_addr_o, 32'h0);
        chk("mrst_pc", if_pc, 32'h0);
        chk("mrst_inst", if_inst, 32'h0);
        chk("mrst_stall", 32'(if_stall_req_o), 32'd1);
        mem_ready_i = 1'b1;
        mem_data_i  = 32'hBAD0_0004;
        tick();
        mem_ready_i = 1'b0;
        mem_data_i  = 32'h0;
        chk("late_pc", if_pc, 32'h0);
        chk("late_inst", if_inst, 32'h0);
        chk("late_stall", 32'(if_stall_req_o), 32'd1);
        wait_req(32'h0);
        respond(word(32'h0), 2);
        chk_hold(32'h0, word(32'h0));
`ifdef ICACHE_EN
        // second pass over 0x0..0x8 hits in the cache
        fetch(32'h4, 1);
        fetch(32'h8, 1);
        branch(32'h0);
        chk("hit_idle_stall", 32'(if_stall_req_o), 32'd1);
        chk("hit_idle_req", 32'(mem_req_o), 32'd0);
        tick();
        chk_hold(32'h0, word(32'h0));
        chk("hit_no_req0", 32'(mem_req_o), 32'd0);
        tick();
        tick();
        chk_hold(32'h4, word(32'h4));
        chk("hit_no_req4", 32'(mem_req_o), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
